context_scheduler: RTL

- Round-robin time-slice scheduler for the MIPS core.
- Holds a saved PC per program slot and counts retired instructions against a quantum.
- On quantum expiry or halt, it sequences register-bank save/load handshakes and loads the next program's PC into the PC block.
- Sits between the control unit/PC and the register file's context save/load logic.

---
 rtl/context_scheduler.sv | 138 +++++++++++++
 1 files changed

// File: rtl/context_scheduler.sv
// Round-robin time-slice scheduler: keeps a saved PC per program slot, counts retired
// instructions against a quantum and sequences register-bank save/load between slices.
module context_scheduler #(
   parameter int NPROC      = 4,
   parameter int QUANTUM    = 16,
   parameter int SLOT_BYTES = 1024,
   parameter int PCW        = 32
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             enable,
   input  logic [NPROC-1:0] proc_valid,
   input  logic             step,
   input  logic             halt,
   input  logic             io_wait,
   input  logic [PCW-1:0]   pc_current,
   input  logic             save_ack,
   input  logic             load_ack,
   output logic             save_req,
   output logic             load_req,
   output logic             pc_load,
   output logic [PCW-1:0]   pc_out,
   output logic [2:0]       cur_pid,
   output logic             running,
   output logic             all_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_SAVE,
      S_SELECT
   } state_t;

   state_t r_state, w_state_nxt;

   // Slot tables span the full 3-bit pid range so cur_pid indexes them directly.
   logic [PCW-1:0] r_pc_table [8];
   logic [7:0]     r_finished;
   logic [7:0]     w_ready;
   logic [15:0]    r_count;
   logic [2:0]     r_cur_pid;
   logic           r_all_done;
   logic           w_dec;
   logic           w_expire;
   logic [2:0]     w_first_ready;
   logic [2:0]     w_next_ready;

   assign w_ready  = 8'(proc_valid) & ~r_finished;
   assign w_dec    = step & ~io_wait;
   assign w_expire = w_dec && (r_count == 16'd1);

   always_comb begin
      w_first_ready = '0;
      for (int unsigned i = 0; i < NPROC; i++) begin
         if (w_ready[3'(NPROC - 1 - i)]) w_first_ready = 3'(NPROC - 1 - i);
      end
      // Farthest offset first so the nearest successor wins; cur_pid itself is checked last.
      w_next_ready = r_cur_pid;
      for (int unsigned k = 0; k < NPROC; k++) begin
         if (w_ready[3'((32'(r_cur_pid) + NPROC - k) % NPROC)])
            w_next_ready = 3'((32'(r_cur_pid) + NPROC - k) % NPROC);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      save_req    = 1'b0;
      load_req    = 1'b0;
      pc_load     = 1'b0;
      pc_out      = '0;
      running     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable && (w_ready != '0)) w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            load_req = 1'b1;
            if (load_ack) begin
               pc_load     = 1'b1;
               pc_out      = r_pc_table[r_cur_pid];
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            running = 1'b1;
            if (halt)          w_state_nxt = S_SELECT;
            else if (w_expire) w_state_nxt = S_SAVE;
         end
         S_SAVE: begin
            save_req = 1'b1;
            if (save_ack) w_state_nxt = S_SELECT;
         end
         S_SELECT: begin
            if ((w_ready == '0) || !enable) w_state_nxt = S_IDLE;
            else                            w_state_nxt = S_LOAD;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_finished <= '0;
         r_count    <= '0;
         r_cur_pid  <= '0;
         r_all_done <= 1'b0;
         for (int unsigned i = 0; i < 8; i++) r_pc_table[i] <= PCW'(i * SLOT_BYTES);
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if ((w_ready == '0) && (proc_valid != '0)) r_all_done <= 1'b1;
               if (enable && (w_ready != '0))             r_cur_pid  <= w_first_ready;
            end
            S_LOAD: begin
               if (load_ack) r_count <= 16'(QUANTUM);
            end
            S_RUN: begin
               if (w_dec && (r_count != '0)) r_count <= r_count - 16'd1;
               if (halt)          r_finished[r_cur_pid] <= 1'b1;
               else if (w_expire) r_pc_table[r_cur_pid] <= pc_current;
            end
            S_SELECT: begin
               if (w_ready == '0) r_all_done <= 1'b1;
               else if (enable)   r_cur_pid  <= w_next_ready;
            end
            default: ;
         endcase
      end
   end

   assign cur_pid  = r_cur_pid;
   assign all_done = r_all_done;

endmodule
